tx_burst_ctrl: RTL and testbench

Parametrised transmit sequencer that drains a burst of words from the tx shift registers into the UART transmitter.
- Handshakes each word with txbusy (wait-rise, then wait-fall).
- Burst length is runtime-selectable, with an optional inter-word gap and a txbusy-rise timeout.
- Supports abort.
- Sits between the top-level control FSM (start_rd/done_rd) and the UART TX plus tx register bank.

---
 rtl/tx_burst_pkg.sv | 55 +++++
 rtl/burst_timer.sv | 39 +++
 rtl/tx_burst_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_tx_burst_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_burst_pkg.sv
// ----------------------------------------------------------------------------
// tx_burst_pkg
// Shared definitions for the transmit burst sequencer:
//   - 3-bit state codes (also shown on the rd_leds status pins)
//   - default burst length and a helper to size the word counter
//   - the Moore output bundle and its state decode
// ----------------------------------------------------------------------------
package tx_burst_pkg;

  // Default maximum number of words in one burst
  localparam int DEF_MAX_WORDS = 32'sd11;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_WAIT_FALL = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  // Moore outputs that follow directly from the state
  typedef struct packed {
    logic txena;
    logic shift_txregs;
    logic load_txregs;
    logic done_rd;
    logic busy;
  } out_dec_t;

  // Counter width able to hold the values 0..max_words
  function automatic int cnt_w_for(input int max_words);
    return $clog2(max_words + 32'sd1);
  endfunction

  // Output decode for a given state; unknown codes decode to all-quiet
  function automatic out_dec_t decode_state(input state_t st);
    out_dec_t d;
    d = '0;
    case (st)
      ST_IDLE:      d.load_txregs = 1'b1;
      ST_SEND: begin
        d.txena        = 1'b1;
        d.shift_txregs = 1'b1;
      end
      ST_DONE,
      ST_ERR:       d.done_rd = 1'b1;
      default:      d.done_rd = 1'b0;
    endcase
    d.busy = (st != ST_IDLE);
    return d;
  endfunction

endpackage

// File: rtl/burst_timer.sv
// ----------------------------------------------------------------------------
// burst_timer
// Small up-counter shared by the inter-word gap and the txbusy-rise timeout.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        force the count to zero (wins over en)
//   en         advance the count by one
//   term       terminal value to compare against
//   at_term    high while the count equals term
// ----------------------------------------------------------------------------
module burst_timer
  import tx_burst_pkg::*;
#(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [TMR_W-1:0] term,
  output logic             at_term
);

  logic [TMR_W-1:0] cnt_r;

  // Count register: reset/clear to zero, otherwise step when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= TMR_W'(0);
    end else if (clr) begin
      cnt_r <= TMR_W'(0);
    end else if (en) begin
      cnt_r <= cnt_r + TMR_W'(1);
    end
  end

  assign at_term = (cnt_r == term);

endmodule

// File: rtl/tx_burst_ctrl.sv
// ----------------------------------------------------------------------------
// tx_burst_ctrl
// Drains a burst of words from the tx shift registers into the UART
// transmitter, handshaking each word on txbusy (wait for rise, then fall).
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start_rd      burst request, only honoured in IDLE with txbusy low
//   len_i         words in burst (0 or > MAX_WORDS means MAX_WORDS)
//   abort         terminate a running burst
//   txbusy        UART transmitter busy
//   txena         one-cycle transmit strobe
//   load_txregs   parallel-load tx registers (high in IDLE)
//   shift_txregs  advance tx registers to the next word
//   done_rd       one-cycle burst-complete pulse (also on timeout)
//   aborted       one-cycle pulse after an abort
//   err_timeout   sticky timeout flag, cleared by the next accepted start
//   busy          high whenever not IDLE
//   word_cnt      words sent in the current or last burst
//   rd_leds       current state code
// ----------------------------------------------------------------------------
module tx_burst_ctrl
  import tx_burst_pkg::*;
#(
  parameter int MAX_WORDS   = DEF_MAX_WORDS,
  parameter int CNT_W       = cnt_w_for(MAX_WORDS),
  parameter int GAP_CYCLES  = 0,
  parameter int TIMEOUT_CYC = 0,
  parameter int TMR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_rd,
  input  logic [CNT_W-1:0] len_i,
  input  logic             abort,
  input  logic             txbusy,
  output logic             txena,
  output logic             load_txregs,
  output logic             shift_txregs,
  output logic             done_rd,
  output logic             aborted,
  output logic             err_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic [2:0]       rd_leds
);

  localparam logic [CNT_W-1:0] MAX_LEN_C  = CNT_W'(MAX_WORDS);
  localparam logic             GAP_EN_C   = (GAP_CYCLES > 0);
  localparam logic             TMO_EN_C   = (TIMEOUT_CYC > 0);
  localparam logic [TMR_W-1:0] GAP_TERM_C = GAP_EN_C ? TMR_W'(GAP_CYCLES - 1) : TMR_W'(0);
  localparam logic [TMR_W-1:0] TMO_TERM_C = TMO_EN_C ? TMR_W'(TIMEOUT_CYC - 1) : TMR_W'(0);

  state_t           state_r;
  state_t           fsm_nxt_s;
  state_t           state_nxt_s;
  out_dec_t         dec_r;
  logic             aborted_r;
  logic             err_timeout_r;
  logic [CNT_W-1:0] word_cnt_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] len_eff_s;
  logic             start_ok_s;
  logic             abort_act_s;
  logic             last_word_s;
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic             tmr_hit_s;
  logic [TMR_W-1:0] tmr_term_s;

  assign start_ok_s  = (state_r == ST_IDLE) && start_rd && !txbusy;
  // Abort only matters while a word is actually in flight
  assign abort_act_s = abort && ((state_r == ST_SEND) || (state_r == ST_WAIT_RISE) ||
                                 (state_r == ST_WAIT_FALL) || (state_r == ST_GAP));
  assign last_word_s = (word_cnt_r == len_r);

  // Timer is zeroed on leaving SEND (timeout window) and throughout WAIT_FALL,
  // so GAP always starts counting from zero.
  assign tmr_clr_s  = (state_r == ST_SEND) || (state_r == ST_WAIT_FALL);
  assign tmr_en_s   = ((state_r == ST_WAIT_RISE) && !txbusy) || (state_r == ST_GAP);
  assign tmr_term_s = (state_r == ST_GAP) ? GAP_TERM_C : TMO_TERM_C;

  burst_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .term    (tmr_term_s),
    .at_term (tmr_hit_s)
  );

  // Clamp the requested burst length to 1..MAX_WORDS
  always_comb begin
    len_eff_s = len_i;
    if ((len_i == CNT_W'(0)) || (len_i > MAX_LEN_C)) begin
      len_eff_s = MAX_LEN_C;
    end else begin
      len_eff_s = len_i;
    end
  end

  // Normal state transitions (timeout included, abort applied afterwards)
  always_comb begin
    fsm_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) fsm_nxt_s = ST_SEND;
        else            fsm_nxt_s = ST_IDLE;
      end
      ST_SEND:      fsm_nxt_s = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (txbusy)                      fsm_nxt_s = ST_WAIT_FALL;
        else if (TMO_EN_C && tmr_hit_s)  fsm_nxt_s = ST_ERR;
        else                             fsm_nxt_s = ST_WAIT_RISE;
      end
      ST_WAIT_FALL: begin
        if (txbusy)           fsm_nxt_s = ST_WAIT_FALL;
        else if (last_word_s) fsm_nxt_s = ST_DONE;
        else if (GAP_EN_C)    fsm_nxt_s = ST_GAP;
        else                  fsm_nxt_s = ST_SEND;
      end
      ST_GAP: begin
        if (tmr_hit_s) fsm_nxt_s = ST_SEND;
        else           fsm_nxt_s = ST_GAP;
      end
      ST_DONE:  fsm_nxt_s = ST_IDLE;
      ST_ERR:   fsm_nxt_s = ST_IDLE;
      default:  fsm_nxt_s = ST_IDLE;
    endcase
  end

  assign state_nxt_s = abort_act_s ? ST_IDLE : fsm_nxt_s;

  // State register plus registered Moore decode of the next state, so the
  // outputs are flop-driven yet line up exactly with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      dec_r     <= decode_state(ST_IDLE);
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      dec_r     <= decode_state(state_nxt_s);
      aborted_r <= abort_act_s;
    end
  end

  // Word counter and latched burst length; an aborted SEND does not count
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_r <= CNT_W'(0);
      len_r      <= MAX_LEN_C;
    end else if (start_ok_s) begin
      word_cnt_r <= CNT_W'(0);
      len_r      <= len_eff_s;
    end else if ((state_r == ST_SEND) && !abort_act_s) begin
      word_cnt_r <= word_cnt_r + CNT_W'(1);
    end
  end

  // Sticky timeout flag: set on leaving ERR, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout_r <= 1'b0;
    end else if (start_ok_s) begin
      err_timeout_r <= 1'b0;
    end else if (state_r == ST_ERR) begin
      err_timeout_r <= 1'b1;
    end
  end

  assign txena        = dec_r.txena;
  assign shift_txregs = dec_r.shift_txregs;
  assign load_txregs  = dec_r.load_txregs;
  assign done_rd      = dec_r.done_rd;
  assign busy         = dec_r.busy;
  assign aborted      = aborted_r;
  assign err_timeout  = err_timeout_r;
  assign word_cnt     = word_cnt_r;
  assign rd_leds      = state_r;

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tx_burst_ctrl
// Directed bench for tx_burst_ctrl (MAX_WORDS=11, GAP_CYCLES=4, TIMEOUT_CYC=8).
// A behavioural model of the burst rules predicts every output each cycle;
// a few hand-computed totals pin the model itself.
// ----------------------------------------------------------------------------
module tb_tx_burst_ctrl;

  localparam int MAXW = 11;
  localparam int GAP  = 4;
  localparam int TMO  = 8;

  localparam int P_IDLE = 0, P_SEND = 1, P_WR = 2, P_WF = 3,
                 P_GAP = 4, P_DONE = 5, P_ERR = 6;

  logic       clk;
  logic       rst;
  logic       start_rd;
  logic [3:0] len_i;
  logic       abort;
  logic       txbusy;
  logic       txena, load_txregs, shift_txregs, done_rd, aborted, err_timeout, busy;
  logic [3:0] word_cnt;
  logic [2:0] rd_leds;

  int n_vec = 0;
  int n_err = 0;

  // running totals taken from DUT outputs
  int n_tx = 0, n_sh = 0, n_dn = 0, n_ab = 0, n_gap = 0, n_wr = 0;

  // UART model state
  bit u_manual = 0;
  bit u_manual_val = 0;
  bit u_pending = 0;
  int u_hold = 0;
  int u_seen = 0;
  int u_resp_until = 1000000;

  // behavioural model state
  int m_ph, m_cnt, m_len, m_wait, m_gap_left;
  bit m_err, m_ab;

  tx_burst_ctrl #(
    .MAX_WORDS   (MAXW),
    .CNT_W       (4),
    .GAP_CYCLES  (GAP),
    .TIMEOUT_CYC (TMO),
    .TMR_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_rd     (start_rd),
    .len_i        (len_i),
    .abort        (abort),
    .txbusy       (txbusy),
    .txena        (txena),
    .load_txregs  (load_txregs),
    .shift_txregs (shift_txregs),
    .done_rd      (done_rd),
    .aborted      (aborted),
    .err_timeout  (err_timeout),
    .busy         (busy),
    .word_cnt     (word_cnt),
    .rd_leds      (rd_leds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: one burst = L words, each word waits for a busy rise
  // (at most TMO cycles), then a busy fall, then GAP idle cycles.
  always @(posedge clk) begin
    if (rst) begin
      m_ph <= P_IDLE; m_cnt <= 0; m_len <= MAXW; m_err <= 1'b0;
      m_ab <= 1'b0; m_wait <= 0; m_gap_left <= 0;
    end else begin
      m_ab <= 1'b0;
      if (abort && (m_ph inside {P_SEND, P_WR, P_WF, P_GAP})) begin
        m_ph <= P_IDLE;
        m_ab <= 1'b1;
      end else begin
        case (m_ph)
          P_IDLE: if (start_rd && !txbusy) begin
            m_len <= (len_i == 4'd0 || int'(len_i) > MAXW) ? MAXW : int'(len_i);
            m_cnt <= 0;
            m_err <= 1'b0;
            m_ph  <= P_SEND;
          end
          P_SEND: begin
            m_cnt  <= m_cnt + 1;
            m_wait <= 0;
            m_ph   <= P_WR;
          end
          P_WR: if (txbusy) m_ph <= P_WF;
                else begin
                  m_wait <= m_wait + 1;
                  if (TMO > 0 && m_wait + 1 == TMO) m_ph <= P_ERR;
                end
          P_WF: if (!txbusy) begin
                  if (m_cnt == m_len) m_ph <= P_DONE;
                  else if (GAP > 0) begin m_gap_left <= GAP; m_ph <= P_GAP; end
                  else m_ph <= P_SEND;
                end
          P_GAP: begin
            m_gap_left <= m_gap_left - 1;
            if (m_gap_left == 1) m_ph <= P_SEND;
          end
          P_DONE: m_ph <= P_IDLE;
          P_ERR: begin m_err <= 1'b1; m_ph <= P_IDLE; end
          default: m_ph <= P_IDLE;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: compare all outputs to the model, tally, then run the UART
  task automatic step();
    @(negedge clk);
    chk("txena",        txena,        m_ph == P_SEND);
    chk("shift_txregs", shift_txregs, m_ph == P_SEND);
    chk("load_txregs",  load_txregs,  m_ph == P_IDLE);
    chk("done_rd",      done_rd,      (m_ph == P_DONE) || (m_ph == P_ERR));
    chk("aborted",      aborted,      m_ab);
    chk("err_timeout",  err_timeout,  m_err);
    chk("busy",         busy,         m_ph != P_IDLE);
    chk("word_cnt",     word_cnt,     m_cnt);
    chk("rd_leds",      rd_leds,      m_ph);
    if (txena === 1'b1)        n_tx++;
    if (shift_txregs === 1'b1) n_sh++;
    if (done_rd === 1'b1)      n_dn++;
    if (aborted === 1'b1)      n_ab++;
    if (rd_leds === 3'd4)      n_gap++;
    if (rd_leds === 3'd2)      n_wr++;
    // UART: busy rises one cycle after txena, stays high 10 cycles
    if (u_manual) begin
      txbusy = u_manual_val;
    end else begin
      if (u_hold > 0) begin
        u_hold--;
        if (u_hold == 0) txbusy = 1'b0;
      end else if (u_pending) begin
        txbusy = 1'b1;
        u_hold = 10;
        u_pending = 1'b0;
      end
      if (txena === 1'b1) begin
        if (u_seen < u_resp_until) u_pending = 1'b1;
        u_seen++;
      end
    end
  endtask

  task automatic start_burst(input logic [3:0] len);
    len_i = len;
    start_rd = 1'b1;
    step();
    start_rd = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (m_ph != P_IDLE && n < 2000) begin step(); n++; end
    chk(nm, m_ph == P_IDLE, 1);
  endtask

  initial begin
    int tx0, sh0, dn0, ab0, gap0, wr0, n;
    rst = 1'b1; start_rd = 1'b0; len_i = 4'd0; abort = 1'b0; txbusy = 1'b0;
    step(); step();
    chk("rst_load", load_txregs, 1);
    chk("rst_cnt",  word_cnt, 0);
    chk("rst_leds", rd_leds, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // len 0 -> full 11-word burst
    tx0 = n_tx; sh0 = n_sh; dn0 = n_dn;
    start_burst(4'd0);
    wait_idle("t1_idle");
    chk("t1_txena_cnt", n_tx - tx0, 11);
    chk("t1_shift_cnt", n_sh - sh0, 11);
    chk("t1_done_cnt",  n_dn - dn0, 1);
    chk("t1_word_cnt",  word_cnt, 11);
    chk("t1_load",      load_txregs, 1);
    step();

    // len 3 with 4-cycle gaps between words
    tx0 = n_tx; dn0 = n_dn; gap0 = n_gap;
    start_burst(4'd3);
    wait_idle("t2_idle");
    chk("t2_txena_cnt", n_tx - tx0, 3);
    chk("t2_done_cnt",  n_dn - dn0, 1);
    chk("t2_gap_cycles", n_gap - gap0, 8);
    chk("t2_word_cnt",  word_cnt, 3);
    step();

    // len 14 clamps to 11
    tx0 = n_tx;
    start_burst(4'd14);
    wait_idle("t2b_idle");
    chk("t2b_txena_cnt", n_tx - tx0, 11);
    chk("t2b_word_cnt",  word_cnt, 11);
    step();

    // start while txbusy high is dropped and not remembered
    tx0 = n_tx;
    u_manual = 1'b1; u_manual_val = 1'b1;
    step();
    start_rd = 1'b1; len_i = 4'd2;
    step(); step(); step();
    chk("t3_busy", busy, 0);
    chk("t3_leds", rd_leds, 0);
    start_rd = 1'b0; u_manual_val = 1'b0;
    step(); step(); step();
    chk("t3_still_idle", rd_leds, 0);
    chk("t3_no_tx", n_tx - tx0, 0);
    u_manual = 1'b0;

    // timeout: UART ignores the 2nd txena
    dn0 = n_dn; wr0 = n_wr; ab0 = n_ab;
    u_resp_until = u_seen + 1;
    start_burst(4'd5);
    wait_idle("t4_idle");
    chk("t4_wr_cycles", n_wr - wr0, 9);
    chk("t4_done_cnt",  n_dn - dn0, 1);
    chk("t4_err",       err_timeout, 1);
    chk("t4_word_cnt",  word_cnt, 2);
    chk("t4_no_abort",  n_ab - ab0, 0);
    u_resp_until = 1000000;
    start_burst(4'd1);
    chk("t4_err_clr", err_timeout, 0);
    wait_idle("t4b_idle");
    step();

    // abort in the same cycle the timeout would fire
    dn0 = n_dn;
    u_resp_until = u_seen;
    start_burst(4'd2);
    n = 0;
    while (!(m_ph == P_WR && m_wait == TMO - 1) && n < 200) begin step(); n++; end
    chk("t5_reach_wr", m_ph == P_WR, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_aborted", aborted, 1);
    chk("t5_no_err",  err_timeout, 0);
    chk("t5_no_done", n_dn - dn0, 0);
    chk("t5_leds",    rd_leds, 0);
    u_resp_until = 1000000;
    step();

    // abort during WAIT_FALL of word 5
    dn0 = n_dn;
    start_burst(4'd0);
    n = 0;
    while (!(m_ph == P_WF && m_cnt == 5) && n < 500) begin step(); n++; end
    chk("t6_reach_wf", m_ph == P_WF, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_aborted",  aborted, 1);
    chk("t6_leds",     rd_leds, 0);
    chk("t6_word_cnt", word_cnt, 5);
    chk("t6_no_done",  n_dn - dn0, 0);
    n = 0;
    while (txbusy && n < 50) begin step(); n++; end
    step();

    // reset during GAP
    start_burst(4'd3);
    n = 0;
    while (m_ph != P_GAP && n < 200) begin step(); n++; end
    chk("t7_reach_gap", m_ph == P_GAP, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_word_cnt", word_cnt, 0);
    chk("t7_leds",     rd_leds, 0);
    chk("t7_load",     load_txregs, 1);
    chk("t7_done",     done_rd, 0);
    chk("t7_aborted",  aborted, 0);
    step();

    // clean burst after reset
    tx0 = n_tx;
    start_burst(4'd2);
    wait_idle("t8_idle");
    chk("t8_txena_cnt", n_tx - tx0, 2);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
